// File: rtl/sha256_pkg.sv
// Constants, types, register map and round helper functions for the
// SHA-256 Avalon-MM compression core.
package sha256_pkg;

    typedef logic [31:0]       word_t;
    typedef logic [7:0][31:0]  hash_t;   // element 0 is a / H0
    typedef logic [15:0][31:0] block_t;  // element 0 is M0 / oldest schedule word

    typedef enum logic [1:0] {IDLE, LOAD, ROUND, FINAL} state_e;

    localparam logic [4:0] ADDR_H_BASE = 5'h10;
    localparam logic [4:0] ADDR_CTRL   = 5'h18;
    localparam logic [4:0] ADDR_STATUS = 5'h19;

    localparam word_t IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam word_t K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t big_sigma0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t big_sigma1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic word_t small_sigma0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t small_sigma1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic word_t ch(input word_t e, input word_t f, input word_t g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic word_t maj(input word_t a, input word_t b, input word_t c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

endpackage

// File: rtl/sha256_avalon_core_round.sv
// One combinational SHA-256 compression round: working variables a..h in,
// next a..h out, for a given round constant and schedule word.
module sha256_round
    import sha256_pkg::*;
(
    input  hash_t vars_i,
    input  word_t k_i,
    input  word_t w_i,
    output hash_t vars_o
);

    word_t t1;
    word_t t2;

    always_comb begin
        t1 = vars_i[7] + big_sigma1(vars_i[4]) + ch(vars_i[4], vars_i[5], vars_i[6]) + k_i + w_i;
        t2 = big_sigma0(vars_i[0]) + maj(vars_i[0], vars_i[1], vars_i[2]);
        vars_o[0] = t1 + t2;
        vars_o[1] = vars_i[0];
        vars_o[2] = vars_i[1];
        vars_o[3] = vars_i[2];
        vars_o[4] = vars_i[3] + t1;
        vars_o[5] = vars_i[4];
        vars_o[6] = vars_i[5];
        vars_o[7] = vars_i[6];
    end

endmodule

// File: rtl/sha256_avalon_core.sv
// Avalon-MM slave SHA-256 block engine: message/digest registers, control FSM,
// rolling 16-word message schedule and one round per clock.
module sha256_avalon_core
    import sha256_pkg::*;
#(
    parameter int ADDR_W    = 5,
    parameter bit BYTE_SWAP = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    output logic [31:0]       avs_readdata,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    output logic              irq
);

    state_e state_q, state_d;
    logic [5:0] t_q, t_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic ie_q, ie_d;
    logic init_q, init_d;
    block_t m_q, m_d;
    block_t w_q, w_d;
    hash_t  h_q, h_d;
    hash_t  v_q, v_d;
    word_t  rdata_q, rdata_d;

    hash_t v_round;
    word_t w_new;
    word_t wdata_m;
    logic  wr_ctrl;

    sha256_round u_round (
        .vars_i (v_q),
        .k_i    (K[t_q]),
        .w_i    (w_q[0]),
        .vars_o (v_round)
    );

    assign w_new   = small_sigma1(w_q[14]) + w_q[9] + small_sigma0(w_q[1]) + w_q[0];
    assign wdata_m = BYTE_SWAP ? {avs_writedata[7:0], avs_writedata[15:8],
                                  avs_writedata[23:16], avs_writedata[31:24]}
                               : avs_writedata;
    assign wr_ctrl = avs_write && (avs_address == ADDR_CTRL);

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        busy_d  = busy_q;
        done_d  = done_q;
        ie_d    = ie_q;
        init_d  = init_q;
        m_d     = m_q;
        w_d     = w_q;
        h_d     = h_q;
        v_d     = v_q;

        // IE stays writable while busy; message words are frozen.
        if (wr_ctrl)
            ie_d = avs_writedata[2];
        if (avs_write && !avs_address[4] && !busy_q)
            m_d[avs_address[3:0]] = wdata_m;

        case (state_q)
            IDLE: begin
                if (wr_ctrl && avs_writedata[0]) begin
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                    init_d  = avs_writedata[1];
                    state_d = LOAD;
                end
            end
            LOAD: begin
                for (int i = 0; i < 8; i++) begin
                    if (init_q)
                        h_d[i] = IV[i];
                    v_d[i] = init_q ? IV[i] : h_q[i];
                end
                w_d     = m_q;
                t_d     = '0;
                state_d = ROUND;
            end
            ROUND: begin
                v_d = v_round;
                for (int i = 0; i < 15; i++)
                    w_d[i] = w_q[i+1];
                w_d[15] = w_new;
                t_d     = t_q + 6'd1;
                if (t_q == 6'd63)
                    state_d = FINAL;
            end
            FINAL: begin
                for (int i = 0; i < 8; i++)
                    h_d[i] = h_q[i] + v_q[i];
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rdata_d = '0;
        if (avs_read) begin
            if (!avs_address[4])
                rdata_d = m_q[avs_address[3:0]];
            else if (avs_address[4:3] == ADDR_H_BASE[4:3])
                rdata_d = h_q[avs_address[2:0]];
            else if (avs_address == ADDR_CTRL)
                rdata_d = {29'b0, ie_q, 2'b0};
            else if (avs_address == ADDR_STATUS)
                rdata_d = {30'b0, done_q, busy_q};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            t_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ie_q    <= 1'b0;
            init_q  <= 1'b0;
            m_q     <= '0;
            w_q     <= '0;
            v_q     <= '0;
            rdata_q <= '0;
            for (int i = 0; i < 8; i++)
                h_q[i] <= IV[i];
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ie_q    <= ie_d;
            init_q  <= init_d;
            m_q     <= m_d;
            w_q     <= w_d;
            v_q     <= v_d;
            rdata_q <= rdata_d;
            h_q     <= h_d;
        end
    end

    assign avs_readdata = rdata_q;
    assign irq          = done_q & ie_q;

endmodule
